// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting NREQ requesters set/reset access to NFLAG shared SR flags.
// Optional SR_FLAG_TOGGLE_EN: S=R=1 toggles the flag instead of raising ERR.

module sr_flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
`ifdef SR_FLAG_TOGGLE_EN
      if (s & r)      q <= ~q;
      else if (s ^ r) q <= s;
`else
      if (s ^ r) q <= s;
`endif
    end
  end
endmodule

module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = $clog2(NFLAG),
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      S,
  input  logic [NREQ-1:0]      R,
  input  logic [NREQ*IDXW-1:0] IDX,
  input  logic                 ERR_ACK,
  output logic [NREQ-1:0]      GNT,
  output logic [NFLAG-1:0]     Q,
  output logic [NFLAG-1:0]     QN,
  output logic                 ERR,
  output logic [PW-1:0]        ERR_ID
);
  typedef enum logic {IDLE, APPLY} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, win_id, cmd_id;
  logic [PW:0]       cand;
  logic              win_vld;
  logic              cmd_s, cmd_r;
  logic [IDXW-1:0]   cmd_idx;
  logic [NFLAG-1:0]  flag, flag_en;
  logic              err_set;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|REQ) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan from the highest offset down so the lowest offset past ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (REQ[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[PW-1:0];
      end
    end
  end

`ifdef SR_FLAG_TOGGLE_EN
  assign err_set = 1'b0;
`else
  assign err_set = (state == APPLY) & cmd_s & cmd_r;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      GNT     <= '0;
      ptr     <= '0;
      cmd_s   <= 1'b0;
      cmd_r   <= 1'b0;
      cmd_idx <= '0;
      cmd_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            GNT     <= NREQ'(1) << win_id;
            cmd_s   <= S[win_id];
            cmd_r   <= R[win_id];
            cmd_idx <= IDX[win_id*IDXW +: IDXW];
            cmd_id  <= win_id;
          end else begin
            GNT <= '0;
          end
        end
        default: begin
          GNT <= '0;
          ptr <= (cmd_id == PW'(NREQ - 1)) ? '0 : cmd_id + PW'(1);
        end
      endcase
    end
  end

  // A fresh error outranks an acknowledge in the same cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ERR    <= 1'b0;
      ERR_ID <= '0;
    end else if (err_set) begin
      ERR    <= 1'b1;
      ERR_ID <= cmd_id;
    end else if (ERR_ACK) begin
      ERR    <= 1'b0;
    end
  end

  for (genvar g = 0; g < NFLAG; g++) begin : g_flag
    assign flag_en[g] = (state == APPLY) && (cmd_idx == IDXW'(g));
    sr_flag_cell u_cell (
      .clk (CLK),
      .rst (CLR),
      .en  (flag_en[g]),
      .s   (cmd_s),
      .r   (cmd_r),
      .q   (flag[g])
    );
  end

  // QN is derived, so it can never disagree with Q.
  assign Q  = flag;
  assign QN = ~flag;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter; expectations follow SR_FLAG_TOGGLE_EN if defined.
module tb_sr_flag_arbiter;
  logic        CLK = 1'b0;
  logic        CLR;
  logic [3:0]  REQ, S, R;
  logic [11:0] IDX;
  logic        ERR_ACK;
  logic [3:0]  GNT;
  logic [7:0]  Q, QN;
  logic        ERR;
  logic [1:0]  ERR_ID;

  int n_vec = 0;
  int n_err = 0;

  sr_flag_arbiter dut (
    .CLK(CLK), .CLR(CLR), .REQ(REQ), .S(S), .R(R), .IDX(IDX),
    .ERR_ACK(ERR_ACK), .GNT(GNT), .Q(Q), .QN(QN), .ERR(ERR), .ERR_ID(ERR_ID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command from requester k and walk it through GNT and APPLY.
  task automatic do_cmd(input int k, input logic s, input logic r,
                        input logic [2:0] idx, input logic ack);
    @(negedge CLK);
    REQ = 4'(1) << k;
    S   = 4'(s) << k;
    R   = 4'(r) << k;
    IDX = 12'(idx) << (k * 3);
    @(negedge CLK);
    chk("gnt", 32'(GNT), 32'(4'(1) << k));
    REQ = '0; S = '0; R = '0; IDX = '0;
    ERR_ACK = ack;
    @(negedge CLK);
    ERR_ACK = 1'b0;
    chk("gnt_clr", 32'(GNT), 32'h0);
  endtask

  initial begin
    CLR = 1'b1; REQ = '0; S = '0; R = '0; IDX = '0; ERR_ACK = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_qn", 32'(QN), 32'hFF);
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    chk("rst_errid", 32'(ERR_ID), 32'h0);
    CLR = 1'b0;

    // Round robin: all requesters hold, pulse every other cycle
    @(negedge CLK);
    REQ = 4'hF;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk($sformatf("rr%0d", i), 32'(GNT),
          (i % 2 == 0) ? 32'(4'(1) << ((i / 2) % 4)) : 32'h0);
    end
    REQ = '0;
    chk("rr_q", 32'(Q), 32'h00);

    // Single requester set then reset of flag 3
    do_cmd(0, 1'b1, 1'b0, 3'd3, 1'b0);
    chk("set3_q", 32'(Q), 32'h08);
    chk("set3_qn", 32'(QN), 32'hF7);
    do_cmd(0, 1'b0, 1'b1, 3'd3, 1'b0);
    chk("rst3_q", 32'(Q), 32'h00);
    chk("rst3_qn", 32'(QN), 32'hFF);

    // Illegal command on flag 1 while it is set
    do_cmd(1, 1'b1, 1'b0, 3'd1, 1'b0);
    chk("set1_q", 32'(Q), 32'h02);
    do_cmd(2, 1'b1, 1'b1, 3'd1, 1'b0);
`ifdef SR_FLAG_TOGGLE_EN
    chk("ill_q", 32'(Q), 32'h00);
    chk("ill_qn", 32'(QN), 32'hFF);
    chk("ill_err", 32'(ERR), 32'h0);
`else
    chk("ill_q", 32'(Q), 32'h02);
    chk("ill_qn", 32'(QN), 32'hFD);
    chk("ill_err", 32'(ERR), 32'h1);
    chk("ill_errid", 32'(ERR_ID), 32'h2);
`endif
    ERR_ACK = 1'b1;
    @(negedge CLK);
    ERR_ACK = 1'b0;
    chk("ack_err", 32'(ERR), 32'h0);

    // Hold command on flag 7, both with flag clear and set
`ifdef SR_FLAG_TOGGLE_EN
    do_cmd(1, 1'b0, 1'b0, 3'd7, 1'b0);
    chk("hold7a_q", 32'(Q), 32'h00);
    do_cmd(3, 1'b1, 1'b0, 3'd7, 1'b0);
    chk("set7_q", 32'(Q), 32'h80);
    do_cmd(1, 1'b0, 1'b0, 3'd7, 1'b0);
    chk("hold7b_q", 32'(Q), 32'h80);
`else
    do_cmd(1, 1'b0, 1'b0, 3'd7, 1'b0);
    chk("hold7a_q", 32'(Q), 32'h02);
    do_cmd(3, 1'b1, 1'b0, 3'd7, 1'b0);
    chk("set7_q", 32'(Q), 32'h82);
    do_cmd(1, 1'b0, 1'b0, 3'd7, 1'b0);
    chk("hold7b_q", 32'(Q), 32'h82);
`endif
    chk("hold_err", 32'(ERR), 32'h0);

    // Error, then a second error landing on the same edge as ERR_ACK
    do_cmd(2, 1'b1, 1'b1, 3'd0, 1'b0);
    do_cmd(3, 1'b1, 1'b1, 3'd0, 1'b1);
`ifdef SR_FLAG_TOGGLE_EN
    chk("col_q", 32'(Q), 32'h80);
    chk("col_err", 32'(ERR), 32'h0);
`else
    chk("col_q", 32'(Q), 32'h82);
    chk("col_err", 32'(ERR), 32'h1);
    chk("col_errid", 32'(ERR_ID), 32'h3);
`endif
    ERR_ACK = 1'b1;
    @(negedge CLK);
    ERR_ACK = 1'b0;
    chk("col_ack", 32'(ERR), 32'h0);

    // Reset asserted mid-APPLY with a pending set of flag 5
    @(negedge CLK);
    REQ = 4'b0001; S = 4'b0001; R = '0; IDX = 12'd5;
    @(negedge CLK);
    chk("pre_rst_gnt", 32'(GNT), 32'h1);
    REQ = '0; S = '0; IDX = '0;
    #2 CLR = 1'b1;
    #1;
    chk("mid_rst_q", 32'(Q), 32'h00);
    chk("mid_rst_qn", 32'(QN), 32'hFF);
    chk("mid_rst_gnt", 32'(GNT), 32'h0);
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("post_rst_q", 32'(Q), 32'h00);
    chk("post_rst_gnt", 32'(GNT), 32'h0);

    // Pointer restarts at 0 after reset
    REQ = 4'b1010;
    @(negedge CLK);
    chk("post_rst_rr", 32'(GNT), 32'h2);
    REQ = '0;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NREQ, 4, number of requesters.
- NFLAG, 8, number of shared SR flags; power of two.
- IDXW, log2(NFLAG) = 3, flag index width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, sole clock; all state updates on its rising edge.
- CLR, in, 1, asynchronous active-high reset.
- REQ, in, NREQ, per-requester request.
- S, in, NREQ, per-requester set command.
- R, in, NREQ, per-requester reset command.
- IDX, in, NREQ*IDXW, per-requester flag index; requester k occupies bits [k*IDXW +: IDXW].
- ERR_ACK, in, 1, clears ERR.
- GNT, out, NREQ, one-hot grant pulse.
- Q, out, NFLAG, flag values.
- QN, out, NFLAG, complement flags.
- ERR, out, 1, sticky illegal-command flag.
- ERR_ID, out, log2(NREQ), requester that caused the last error.

Function
REQ-003 The FSM SHALL have two states: IDLE and APPLY.
REQ-004 In IDLE with REQ != 0, the block SHALL do the following at the clock edge, then enter APPLY:
- select a winner round-robin, searching from PTR upward and wrapping at NREQ;
- latch the winner's S, R and IDX into command registers;
- drive GNT = onehot(winner) for exactly one cycle.
REQ-005 In IDLE with REQ == 0, the block SHALL hold state, and GNT SHALL be 0.
REQ-006 In APPLY, the block SHALL do the following at the clock edge, then return to IDLE:
- apply the latched command to flag[IDX];
- clear GNT;
- set PTR = (winner+1) mod NREQ.
REQ-007 REQ, S, R and IDX are not sampled in APPLY; a requester SHALL hold its inputs stable until it sees GNT, and may change them from the edge that ends the GNT cycle.
REQ-008 Timing SHALL be as follows:
- Latency: a request sampled at edge N gives GNT high from edge N to N+1, with Q/QN updated at edge N+1.
- Throughput: one command per 2 cycles.
REQ-009 Command decode SHALL be:
- S!=R: Q[IDX]=S, QN[IDX]=R.
- S=R=0: hold.
- S=R=1: illegal, handled per REQ-016/017.
REQ-010 Q and QN SHALL be the complements of each other for every flag at all times.
REQ-011 Only flag[IDX] SHALL change in an APPLY cycle; all other flags SHALL hold.
REQ-012 ERR SHALL set in the APPLY cycle of an illegal command, with ERR_ID = winner.
- ERR_ACK with no new error: ERR clears at the next edge.
- New error in the same cycle as ERR_ACK: set wins, and ERR_ID is updated.
- A later illegal command while ERR=1 SHALL overwrite ERR_ID.
REQ-013 Fairness: a requester holding REQ high SHALL be granted within NREQ grants.

Reset
REQ-014 CLR=1 SHALL take effect immediately, independent of CLK, and set:
- Q=0, QN=all ones, GNT=0, ERR=0, ERR_ID=0;
- PTR=0, FSM=IDLE, command registers 0.
REQ-015 If CLR is asserted during APPLY, the pending command SHALL be discarded. After CLR is released, the first edge SHALL behave as IDLE.

Configuration
REQ-016 With SR_FLAG_TOGGLE_EN defined, an S=R=1 command SHALL invert flag[IDX] (Q and QN swap), and ERR SHALL stay unaffected.
REQ-017 Without SR_FLAG_TOGGLE_EN, an S=R=1 command SHALL leave flag[IDX] unchanged and set ERR/ERR_ID per REQ-012.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset: CLR=1 mid-APPLY, with a command setting flag 5 pending -> Q=0x00, QN=0xFF and GNT=0 immediately; after release, flag 5 is still 0.
- Single request: REQ=0001, S=1, R=0, IDX0=3 -> GNT=0001 for one cycle, then Q=0x08, QN=0xF7. Repeating with S=0, R=1 -> Q=0x00.
- Round robin: REQ=1111 held for 8 grants from reset -> GNT sequence 0001, 0010, 0100, 1000, 0001, ..., with a GNT pulse every 2nd cycle.
- Illegal command, macro off: requester 2 sends S=R=1, IDX=1, with Q=0x02 -> Q unchanged, ERR=1, ERR_ID=2. ERR_ACK for one cycle -> ERR=0.
- Illegal command, macro on: the same stimulus -> Q=0x00, QN=0xFF, ERR=0.
- Hold and collision: requester 1 sends S=R=0 on flag 7 -> no change. A new error in the same cycle as ERR_ACK -> ERR stays 1.
